// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder. It uses one full-adder cell and a carry flip-flop, and
// processes the operands LSB first at one bit per clock. An operation takes
// one load cycle, WIDTH RUN cycles and one DONE cycle, in that order.
//
// Parameters
//   WIDTH  operand width in bits (2..32)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  begin an addition (sampled in IDLE only)
//   a, b   operands, captured with start
//   cin    carry-in, captured with start
//   busy   high exactly while bits are being processed (RUN)
//   done   one-cycle pulse marking a valid result (DONE)
//   sum    registered result, held until the next completion
//   cout   registered carry-out of bit WIDTH-1
//   ovf    signed overflow, present only when SERIAL_ADDER_OVF_EN is defined
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   res;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               last_bit;
    logic               fa_sum;
    logic               fa_carry;

    // The bit being processed this cycle is the final one.
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Full-adder cell that operates on the current operand LSBs.
    assign fa_sum   = opa[0] ^ opb[0] ^ carry;
    assign fa_carry = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));

    // State register. busy and done are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand load, serial shift/add, and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    res   <= {fa_sum, res[WIDTH-1:1]};
                    carry <= fa_carry;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum  <= {fa_sum, res[WIDTH-1:1]};
                        cout <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        // The carry flop holds the carry into the MSB here.
                        ovf  <= carry ^ fa_carry;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder. An 8-bit instance runs the table
// vectors and the corner-case sequences. A 4-bit instance runs every
// combination of a, b and cin. Expected results go into queues when an
// operation is driven. Monitors pop and compare them on each done pulse.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int unsigned W  = 8;
    localparam int unsigned W4 = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
    logic         ovf4;
`endif

    logic          start4 = 1'b0;
    logic          cin4 = 1'b0;
    logic [W4-1:0] a4 = '0;
    logic [W4-1:0] b4 = '0;
    logic          busy4, done4, cout4;
    logic [W4-1:0] sum4;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf4)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        res_t         exp;
    } vec_t;

    res_t         exp_q[$];
    logic [W4:0]  exp4_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard for the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(exp_q.size()), 32'd1);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Scoreboard for the 4-bit instance.
    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (exp4_q.size() == 0) begin
                chk("unexpected_done4", 32'(exp4_q.size()), 32'd1);
            end else begin
                logic [W4:0] e4;
                e4 = exp4_q.pop_front();
                chk("w4_sum_cout", 32'({cout4, sum4}), 32'(e4));
            end
        end
    end

    // Runs one 8-bit addition. Inputs are scrambled after the sampling edge,
    // and the previous result must hold through the whole RUN phase.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input res_t e);
        int           busy_cycles;
        bit           seen;
        bit           held;
        logic [W-1:0] prev_sum;
        @(negedge clk);
        prev_sum = sum;
        a = ta; b = tb; cin = tc; start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tb; cin = ~tc;
        busy_cycles = 0; seen = 0; held = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_cycles++;
                if (sum !== prev_sum) held = 0;
                @(negedge clk);
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_cycles", 32'(busy_cycles), 32'(W));
        chk("sum_held_in_run", 32'(held), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'({busy, done}), 32'd0);
    endtask

    // Runs one 4-bit addition. The monitor compares the result.
    task automatic run4(input logic [W4-1:0] ta, input logic [W4-1:0] tb, input logic tc);
        bit seen;
        @(negedge clk);
        a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
        exp4_q.push_back((W4+1)'(ta) + (W4+1)'(tb) + (W4+1)'(tc));
        @(negedge clk);
        start4 = 1'b0;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (done4) seen = 1;
            else @(negedge clk);
        end
        if (!seen) chk("w4_done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        vec_t vecs[8];
        int   dn[2];
        int   k;

        vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, exp: '{sum: 8'h10, cout: 1'b0, ovf: 1'b0}};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp: '{sum: 8'h00, cout: 1'b1, ovf: 1'b0}};
        vecs[2] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, exp: '{sum: 8'h80, cout: 1'b0, ovf: 1'b1}};
        vecs[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp: '{sum: 8'hFF, cout: 1'b1, ovf: 1'b0}};
        vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, exp: '{sum: 8'h01, cout: 1'b0, ovf: 1'b0}};
        vecs[5] = '{a: 8'h55, b: 8'h55, cin: 1'b0, exp: '{sum: 8'hAA, cout: 1'b0, ovf: 1'b1}};
        vecs[6] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp: '{sum: 8'h00, cout: 1'b1, ovf: 1'b1}};
        vecs[7] = '{a: 8'h12, b: 8'h34, cin: 1'b0, exp: '{sum: 8'h46, cout: 1'b0, ovf: 1'b0}};

        // Reset state.
        #3 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("reset_outputs", 32'({busy, done, cout, sum}), 32'd0);
        rst_n = 1'b1;

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);
        end

        // Start held high: done pulses 10 cycles apart, and a change on a
        // during RUN does not affect the result.
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        exp_q.push_back('{sum: 8'h46, cout: 1'b0, ovf: 1'b0});
        exp_q.push_back('{sum: 8'h46, cout: 1'b0, ovf: 1'b0});
        k = 0; dn[0] = 0; dn[1] = 0;
        for (int n = 1; n <= 30 && k < 2; n++) begin
            @(negedge clk);
            if (n == 3) a = 8'hAA;
            if (n == 6) a = 8'h12;
            if (n == 15) chk("hold_during_next_run", 32'({busy, sum}), 32'h146);
            if (done) begin
                dn[k] = n;
                k++;
                if (k == 2) start = 1'b0;
            end
        end
        chk("cont_done_count", 32'(k), 32'd2);
        chk("cont_first_latency", 32'(dn[0]), 32'd9);
        chk("cont_spacing", 32'(dn[1] - dn[0]), 32'd10);
        @(negedge clk); @(negedge clk);

        // Reset asserted on the 4th RUN cycle of 0x55+0x55.
        @(negedge clk);
        a = 8'h55; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("mid_run_reset", 32'({busy, done, cout, sum}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h55, 8'h55, 1'b0, '{sum: 8'hAA, cout: 1'b0, ovf: 1'b1});

        // Exhaustive check on the 4-bit instance.
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run4(W4'(ia), W4'(ib), 1'(ic));

        @(negedge clk); @(negedge clk);
        chk("queue8_drained", 32'(exp_q.size()), 32'd0);
        chk("queue4_drained", 32'(exp4_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
